// File: rtl/word_deserializer.sv
// Receive-side word deserializer: gathers N_SAMPLES words from a val/rdy
// stream into one packed vector, presented on a val/rdy output.
module word_deserializer #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int               CNT_W = $clog2(N_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic {COLLECT, FULL} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] slot_q [N_SAMPLES];
  logic                 wr_en;
  logic [CNT_W-1:0]     wr_idx;
  logic                 recv_fire;
  logic                 send_fire;

  assign send_val  = (state_q == FULL);
  // While full, a word can only enter when the held vector leaves this cycle.
  assign recv_rdy  = reset & ((state_q == COLLECT) | send_rdy);
  assign recv_fire = recv_val & recv_rdy;
  assign send_fire = send_val & send_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    case (state_q)
      COLLECT: begin
        if (recv_fire) begin
          wr_en = 1'b1;
          if (cnt_q == LAST) begin
            state_d = FULL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      FULL: begin
        if (send_fire) begin
          if (recv_fire) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            if (N_SAMPLES == 1) begin
              state_d = FULL;
              cnt_d   = '0;
            end else begin
              state_d = COLLECT;
              cnt_d   = ONE;
            end
          end else begin
            state_d = COLLECT;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (!reset) begin
        slot_q[i] <= '0;
      end else if (wr_en && (wr_idx == CNT_W'(i))) begin
        slot_q[i] <= recv_msg;
      end
    end
  end

  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_pack
    assign send_msg[BIT_WIDTH*g +: BIT_WIDTH] = slot_q[g];
  end

endmodule

// File: tb/tb_word_deserializer.sv
// Scoreboard bench for word_deserializer: N=8 and N=1 instances fed from a
// behavioural serializer, with a monitor comparing every vector handed out.
module tb_word_deserializer;

  localparam int BW = 32;
  localparam int N  = 8;
  localparam int VW = BW * N;

  logic          clk;
  logic          reset;
  logic [BW-1:0] recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [VW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy;

  logic [BW-1:0] recv_msg1;
  logic          recv_val1;
  logic          recv_rdy1;
  logic [BW-1:0] send_msg1;
  logic          send_val1;
  logic          send_rdy1;

  logic [VW-1:0] exp_q[$];
  logic [BW-1:0] exp1_q[$];

  int checks    = 0;
  int failures  = 0;
  int stalls    = 0;
  int fires0    = 0;
  int fires1    = 0;
  int rdy_mode  = 0;

  word_deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  word_deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg1),
    .recv_val (recv_val1),
    .recv_rdy (recv_rdy1),
    .send_msg (send_msg1),
    .send_val (send_val1),
    .send_rdy (send_rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed vector whose slot i holds base+i.
  function automatic logic [VW-1:0] seq_vec(input logic [BW-1:0] base);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*BW +: BW] = base + BW'(k);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*BW +: BW] = $urandom();
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the word was taken.
  task automatic send_word(input bit which, input logic [BW-1:0] w);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    if (which) begin recv_val1 = 1'b1; recv_msg1 = w; end
    else       begin recv_val  = 1'b1; recv_msg  = w; end
    while (!done) begin
      @(negedge clk);
      done = which ? recv_rdy1 : recv_rdy;
      if (!done) stalls++;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 1000) begin
        checks++;
        failures++;
        $display("FAIL word_timeout: word %h not accepted within %0d cycles", w, n);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_vec(input logic [VW-1:0] v, input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          recv_val = 1'b0;
          recv_msg = $urandom();
          @(posedge clk);
          #1;
        end
      end
      send_word(1'b0, v[k*BW +: BW]);
    end
  endtask

  task automatic rdy_loop();
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       send_rdy = 1'b1;
        1:       send_rdy = ($urandom_range(0, 2) != 0);
        default: send_rdy = 1'b0;
      endcase
      send_rdy1 = $urandom_range(0, 1) != 0;
    end
  endtask

  task automatic monitor_loop();
    bit            stall0, stall1;
    logic [VW-1:0] hold0;
    logic [BW-1:0] hold1;
    logic [VW-1:0] e;
    logic [BW-1:0] e1;
    stall0 = 1'b0;
    stall1 = 1'b0;
    hold0  = '0;
    hold1  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall0 = 1'b0;
        stall1 = 1'b0;
      end else begin
        if (stall0) begin
          chk("hold_val0", VW'(send_val), VW'(1));
          chk("hold_msg0", send_msg, hold0);
        end
        if (send_val && send_rdy) begin
          fires0++;
          if (exp_q.size() == 0) begin
            chk("unexpected_vec0", send_msg, '0);
            checks++;
            failures++;
            $display("FAIL extra_vec0: got vector %h with no vector expected", send_msg);
          end else begin
            e = exp_q.pop_front();
            chk("vec0", send_msg, e);
          end
        end
        stall0 = send_val && !send_rdy;
        hold0  = send_msg;

        if (stall1) begin
          chk("hold_val1", VW'(send_val1), VW'(1));
          chk("hold_msg1", VW'(send_msg1), VW'(hold1));
        end
        if (send_val1 && send_rdy1) begin
          fires1++;
          if (exp1_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_vec1: got vector %h with no vector expected", send_msg1);
          end else begin
            e1 = exp1_q.pop_front();
            chk("vec1", VW'(send_msg1), VW'(e1));
          end
        end
        stall1 = send_val1 && !send_rdy1;
        hold1  = send_msg1;
      end
    end
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] vs [4];
    int            f0;
    int            t;

    reset     = 1'b0;
    recv_val  = 1'b1;
    recv_msg  = 32'h55;
    send_rdy  = 1'b1;
    recv_val1 = 1'b0;
    recv_msg1 = '0;
    send_rdy1 = 1'b0;

    fork
      monitor_loop();
      rdy_loop();
    join_none

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_recv_rdy", VW'(recv_rdy), VW'(0));
    chk("rst_send_val", VW'(send_val), VW'(0));
    chk("rst_send_msg", send_msg, '0);
    chk("rst_recv_rdy1", VW'(recv_rdy1), VW'(0));
    @(posedge clk);
    #1;
    reset    = 1'b1;
    recv_val = 1'b0;
    @(negedge clk);
    chk("rel_recv_rdy", VW'(recv_rdy), VW'(1));
    @(posedge clk);
    #1;

    // Basic vector and output latency
    exp_q.push_back(seq_vec(32'h10));
    send_vec(seq_vec(32'h10), 1'b0);
    recv_val = 1'b0;
    @(negedge clk);
    chk("latency_send_val", VW'(send_val), VW'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_fire_send_val", VW'(send_val), VW'(0));
    @(posedge clk);
    #1;

    // Backpressure while full
    rdy_mode = 2;
    exp_q.push_back(seq_vec(32'h30));
    send_vec(seq_vec(32'h30), 1'b0);
    recv_val = 1'b1;
    recv_msg = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_recv_rdy", VW'(recv_rdy), VW'(0));
      chk("bp_send_val", VW'(send_val), VW'(1));
      chk("bp_send_msg", send_msg, seq_vec(32'h30));
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    v = seq_vec(32'h60);
    v[BW-1:0] = 32'hDEAD;
    exp_q.push_back(v);
    @(negedge clk);
    chk("bp_release_recv_rdy", VW'(recv_rdy), VW'(1));
    @(posedge clk);
    #1;
    recv_msg = 32'h61;
    @(negedge clk);
    chk("bp_slot0_val", VW'(send_val), VW'(0));
    chk("bp_slot0_msg", VW'(send_msg[BW-1:0]), VW'(32'hDEAD));
    @(posedge clk);
    #1;
    for (int k = 2; k < N; k++) send_word(1'b0, 32'h60 + BW'(k));
    recv_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Streaming: four vectors back-to-back
    stalls = 0;
    f0 = fires0;
    for (int i = 0; i < 4; i++) begin
      vs[i] = rand_vec();
      exp_q.push_back(vs[i]);
    end
    for (int i = 0; i < 4; i++) send_vec(vs[i], 1'b0);
    recv_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stream_stalls", VW'(stalls), VW'(0));
    chk("stream_fires", VW'(fires0 - f0), VW'(4));

    // Reset in the middle of a vector
    for (int k = 0; k < 3; k++) send_word(1'b0, 32'h50 + BW'(k));
    recv_val = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back(seq_vec(32'hA0));
    send_vec(seq_vec(32'hA0), 1'b0);
    recv_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Random stalls on both sides, N=8 then N=1
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      v = rand_vec();
      exp_q.push_back(v);
      send_vec(v, 1'b1);
    end
    recv_val = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic [BW-1:0] w;
      int g;
      w = $urandom();
      g = $urandom_range(0, 2);
      repeat (g) begin
        recv_val1 = 1'b0;
        recv_msg1 = $urandom();
        @(posedge clk);
        #1;
      end
      exp1_q.push_back(w);
      send_word(1'b1, w);
    end
    recv_val1 = 1'b0;

    t = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_q0", VW'(exp_q.size()), VW'(0));
    chk("drain_q1", VW'(exp1_q.size()), VW'(0));
    chk("fires1_total", VW'(fires1), VW'(24));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
